// File: rtl/i2s_pkg.sv
// Shared definitions for the I2S capture scheduler: FSM state encoding, frame geometry, out_chan width helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package i2s_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SYNC    = 2'd1,
      CAPTURE = 2'd2
   } state_e;

   // Plain-vector copies of the state encoding for legacy-style state registers.
   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_SYNC    = 2'd1;
   localparam logic [1:0] ST_CAPTURE = 2'd2;

   localparam int FRAME_BITS = 64;
   localparam int HALF_BITS  = 32;

   // out_chan carries {line index, lr}; one extra bit beyond the line index.
   function automatic int chan_w(input int channels);
      return $clog2(channels) + 1;
   endfunction

endpackage

// File: rtl/i2s_shift_in.sv
// MSB-first serial-to-parallel shifter for one I2S data line; new bit enters at the LSB end.
// Latency: word reflects a shifted bit the cycle after shift_en.
// Backpressure: none; shifts whenever shift_en is high.
// Ports: ck/rst_n (sync active-low), shift_en, sd (serial bit), word (parallel WIDTH-bit value).
module i2s_shift_in
   import i2s_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             ck,
   input  logic             rst_n,
   input  logic             shift_en,
   input  logic             sd,
   output logic [WIDTH-1:0] word
);

   logic [WIDTH-1:0] word_q;
   logic [WIDTH-1:0] word_d;

   always_comb begin
      word_d = word_q;
      // Cast drops the oldest bit; also works for WIDTH == 1.
      if (shift_en) word_d = WIDTH'({word_q, sd});
   end

   always_ff @(posedge ck) begin
      if (!rst_n) word_q <= '0;
      else        word_q <= word_d;
   end

   assign word = word_q;

endmodule

// File: rtl/i2s_capture_scheduler.sv
// Captures CHANNELS I2S data lines, latches a left/right bank every half-frame, drains it round-robin on one stream.
// Latency: bank latched in cycle T is presented (line 0) in T+1; one word per cycle while out_ready is high.
// Backpressure: out_valid/out_ready; held word stays stable; a latch onto an undrained bank replaces it.
// Ports: ck, rst_n (sync active-low), en/frame_posn (bit clock strobe and frame position), sd[CHANNELS],
//        run, busy, out_valid/out_ready/out_data/out_chan; overrun/overrun_clr only when I2S_SCHED_OVERRUN_EN is defined.
module i2s_capture_scheduler
   import i2s_pkg::*;
#(
   parameter int CHANNELS = 4,
   parameter int WIDTH    = 16
) (
   input  logic                          ck,
   input  logic                          rst_n,
   input  logic                          en,
   input  logic [5:0]                    frame_posn,
   input  logic [CHANNELS-1:0]           sd,
   input  logic                          run,
   output logic                          busy,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [WIDTH-1:0]              out_data,
   output logic [chan_w(CHANNELS)-1:0]   out_chan
`ifdef I2S_SCHED_OVERRUN_EN
   ,
   output logic                          overrun,
   input  logic                          overrun_clr
`endif
);

   localparam int IW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam int CW = chan_w(CHANNELS);

   logic [1:0]          state_q, state_d;
   logic                busy_q;
   logic [CHANNELS-1:0] pending_q, pending_d, pend_after_hs;
   logic [IW-1:0]       ptr_q, ptr_d;
   logic [IW-1:0]       cur_q, cur_d;
   logic                bank_lr_q, bank_lr_d;
   logic [WIDTH-1:0]    bank_q [CHANNELS];
   logic [WIDTH-1:0]    bank_d [CHANNELS];
   logic [WIDTH-1:0]    sh_word [CHANNELS];
   logic [WIDTH-1:0]    sh_next [CHANNELS];
   logic                out_valid_q, out_valid_d;
   logic [WIDTH-1:0]    out_data_q, out_data_d;
   logic [CW-1:0]       out_chan_q, out_chan_d;

   logic [4:0]          slot;
   logic                data_slot;
   logic                shift_en;
   logic                latch;
   logic                hs;
   logic                repl;
   logic [IW-1:0]       sel;
   logic                found;

   assign slot      = frame_posn[4:0];
   assign data_slot = en && (slot >= 5'd1) && (slot <= 5'(WIDTH));
   assign shift_en  = (state_q == ST_CAPTURE) && data_slot;
   assign latch     = (state_q == ST_CAPTURE) && en && (slot == 5'(WIDTH));

   for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_line
      i2s_shift_in #(.WIDTH(WIDTH)) u_shift (
         .ck       (ck),
         .rst_n    (rst_n),
         .shift_en (shift_en),
         .sd       (sd[gi]),
         .word     (sh_word[gi])
      );
   end

   // The bank must include the bit arriving in the latch cycle, so look one shift ahead.
   always_comb begin
      for (int i = 0; i < CHANNELS; i++) sh_next[i] = WIDTH'({sh_word[i], sd[i]});
   end

   // Capture state machine: transitions only on frame boundaries except SYNC abort.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:    if (run) state_d = ST_SYNC;
         ST_SYNC: begin
            if (!run)                             state_d = ST_IDLE;
            else if (en && frame_posn == 6'd0)    state_d = ST_CAPTURE;
         end
         ST_CAPTURE: if (en && frame_posn == 6'd0 && !run) state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   // Pending/pointer update, bank load and next presented word. Outputs are
   // registered, so the word for next cycle is chosen from the next-state mask.
   always_comb begin
      hs            = out_valid_q && out_ready;
      pend_after_hs = pending_q;
      ptr_d         = ptr_q;
      if (hs) begin
         pend_after_hs[cur_q] = 1'b0;
         ptr_d = (cur_q == IW'(CHANNELS - 1)) ? '0 : cur_q + IW'(1);
      end

      // A same-cycle handshake counts as delivered before judging the bank non-empty.
      repl      = latch && (|pend_after_hs);
      pending_d = pend_after_hs;
      bank_lr_d = bank_lr_q;
      for (int i = 0; i < CHANNELS; i++) bank_d[i] = bank_q[i];
      if (latch) begin
         pending_d = '1;
         ptr_d     = '0;
         bank_lr_d = frame_posn[5];
         for (int i = 0; i < CHANNELS; i++) bank_d[i] = sh_next[i];
      end

      // Lowest pending line at or above the pointer; fall back to lowest pending overall.
      sel   = '0;
      found = 1'b0;
      for (int i = CHANNELS - 1; i >= 0; i--) begin
         if (pending_d[i] && (IW'(i) >= ptr_d)) begin
            sel   = IW'(i);
            found = 1'b1;
         end
      end
      if (!found) begin
         for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (pending_d[i]) sel = IW'(i);
         end
      end
      cur_d = sel;

      // Replacement drops valid for one cycle so the consumer sees the new bank restart at line 0.
      out_valid_d = (|pending_d) && !repl;
      out_data_d  = out_data_q;
      out_chan_d  = out_chan_q;
      if (out_valid_d) begin
         out_data_d = bank_d[sel];
         out_chan_d = CW'({sel, bank_lr_d});
      end
   end

   always_ff @(posedge ck) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         busy_q      <= 1'b0;
         pending_q   <= '0;
         ptr_q       <= '0;
         cur_q       <= '0;
         bank_lr_q   <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_chan_q  <= '0;
         for (int i = 0; i < CHANNELS; i++) bank_q[i] <= '0;
      end else begin
         state_q     <= state_d;
         busy_q      <= (state_d != ST_IDLE);
         pending_q   <= pending_d;
         ptr_q       <= ptr_d;
         cur_q       <= cur_d;
         bank_lr_q   <= bank_lr_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_chan_q  <= out_chan_d;
         for (int i = 0; i < CHANNELS; i++) bank_q[i] <= bank_d[i];
      end
   end

   assign busy      = busy_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_chan  = out_chan_q;

`ifdef I2S_SCHED_OVERRUN_EN
   logic overrun_q, overrun_d;

   // Set has priority over clear so a replacement is never lost.
   always_comb begin
      overrun_d = overrun_q;
      if (overrun_clr) overrun_d = 1'b0;
      if (repl)        overrun_d = 1'b1;
   end

   always_ff @(posedge ck) begin
      if (!rst_n) overrun_q <= 1'b0;
      else        overrun_q <= overrun_d;
   end

   assign overrun = overrun_q;
`endif

endmodule
